fifo_param_umbrales: RTL

//  Parametrised synchronous FIFO. Successor to the single-mode ring-buffer FIFO.

---
 rtl/fifo_param_umbrales.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_param_umbrales.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, occupancy, sticky errors and flush.
// Read latency 1 cycle (FWFT=0) or 0 (FWFT=1); writes while full are dropped and flagged, never stalled.
module fifo_param_umbrales #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 32,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4,
   parameter bit FWFT     = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       wr_en,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       vacio,
   output logic                       lleno,
   output logic                       casi_vacio,
   output logic                       casi_lleno,
   output logic [$clog2(DEPTH+1)-1:0] nivel,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
   localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    nivel_nxt;
   logic             rd_acc;
   logic             wr_acc;

   // vacio/lleno are active-low, so they read directly as "has data" / "has room".
   assign rd_acc = rd_en & vacio;
   assign wr_acc = wr_en & (lleno | rd_acc);

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      nivel_nxt = nivel;
      if (wr_acc && !rd_acc)
         nivel_nxt = nivel + 1'b1;
      else if (rd_acc && !wr_acc)
         nivel_nxt = nivel - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         nivel      <= '0;
         vacio      <= 1'b0;
         lleno      <= 1'b1;
         casi_vacio <= 1'b1;
         casi_lleno <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= bump(wr_ptr);
         if (rd_acc)
            rd_ptr <= bump(rd_ptr);
         nivel      <= nivel_nxt;
         vacio      <= (nivel_nxt != '0);
         lleno      <= (nivel_nxt != LVL_FULL);
         casi_vacio <= (nivel_nxt <= LVL_AE);
         casi_lleno <= (nivel_nxt >= LVL_AF);
         if (wr_en && !wr_acc)
            overflow <= 1'b1;
         if (rd_en && !rd_acc)
            underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !clear && wr_acc)
         mem[wr_ptr] <= data_in;
   end

   generate
      if (FWFT) begin : g_fwft
         assign data_out = mem[rd_ptr];
      end else begin : g_reg
         always_ff @(posedge clk) begin
            if (rst || clear)
               data_out <= '0;
            else if (rd_acc)
               data_out <= mem[rd_ptr];
         end
      end
   endgenerate

endmodule
